// File: rtl/hack_pkg.sv
// hack_pkg: word width and routing constants shared by the 16-bit mux/demux blocks.
package hack_pkg;
    localparam int DEF_WIDTH = 16;
    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;
endpackage

// File: rtl/fifo16_sync.sv
// fifo16_sync: synchronous FIFO with count, full/empty and head-of-queue data.
module fifo16_sync
    import hack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;

    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    // full is judged on the registered count, so a same-cycle pop never frees room for a push
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr <= wptr + AW'(1);
            end
            if (do_pop) rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/dmux16_2way_stream.sv
// dmux16_2way_stream: routes a valid/ready word stream to port A (sel=1) or B (sel=0),
// each side buffered by its own FIFO so one stalled consumer does not block the other.
module dmux16_2way_stream
    import hack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [CW-1:0]    a_count,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CW-1:0]    b_count
);
    logic full_a, full_b, empty_a, empty_b, push_a, push_b;

    // ready comes only from registered occupancy, never from the consumers' ready
    assign in_ready = ~reset & (in_sel == SEL_A ? ~full_a : ~full_b);
    assign push_a = in_valid & in_ready & (in_sel == SEL_A);
    assign push_b = in_valid & in_ready & (in_sel == SEL_B);
    assign a_valid = ~empty_a;
    assign b_valid = ~empty_b;

    fifo16_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .reset(reset), .push(push_a), .wdata(in_data), .pop(a_ready),
        .rdata(a_data), .count(a_count), .full(full_a), .empty(empty_a)
    );

    fifo16_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .reset(reset), .push(push_b), .wdata(in_data), .pop(b_ready),
        .rdata(b_data), .count(b_count), .full(full_b), .empty(empty_b)
    );
endmodule

// File: tb/tb_dmux16_2way_stream.sv
// tb_dmux16_2way_stream: directed stimulus with per-port expected-word queues
// drained by an independent output monitor.
module tb_dmux16_2way_stream;
    logic clk = 0;
    logic reset;
    logic [15:0] in_data;
    logic in_sel, in_valid, in_ready;
    logic [15:0] a_data, b_data;
    logic a_valid, b_valid, a_ready, b_ready;
    logic [1:0] a_count, b_count;
    logic tog = 0;
    int tests = 0;
    int fails = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    dmux16_2way_stream dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .a_count(a_count), .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .b_count(b_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // waits (bounded) for in_ready, records the expected word, then lets the edge accept it
    task automatic send(input logic sel, input logic [15:0] d);
        int n = 0;
        in_valid = 1;
        in_sel = sel;
        in_data = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stuck at 0 for word %0h", d);
        end else if (sel) qa.push_back(d);
        else qb.push_back(d);
        step();
    endtask

    always begin
        @(posedge clk);
        #1;
        if (tog) b_ready = ~b_ready;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (a_valid && a_ready) begin
                if (qa.size() == 0) chk("a_extra_word", 32'(qa.size()), 1);
                else chk("a_data", a_data, qa.pop_front());
            end
            if (b_valid && b_ready) begin
                if (qb.size() == 0) chk("b_extra_word", 32'(qb.size()), 1);
                else chk("b_data", b_data, qb.pop_front());
            end
            if (a_count > 2 || b_count > 2) begin
                fails++;
                $display("FAIL count_bound: a_count %0d b_count %0d exceed 2", a_count, b_count);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd [3] = '{16'h0001, 16'h0002, 16'h0003};
        logic rs [3] = '{1'b1, 1'b0, 1'b1};
        reset = 1; in_valid = 1; in_sel = 1; in_data = 16'hFFFF; a_ready = 0; b_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_a_count", a_count, 0);
        chk("rst_b_count", b_count, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_b_data", b_data, 0);
        step();
        reset = 0;
        qa.push_back(16'hFFFF);
        step();
        in_valid = 0;
        @(negedge clk);
        chk("first_a_valid", a_valid, 1);
        chk("first_a_data", a_data, 16'hFFFF);
        chk("first_a_count", a_count, 1);
        step();
        a_ready = 1; b_ready = 1;
        step();
        // routing: back-to-back words, each visible one edge after acceptance
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_sel = rs[i]; in_data = rd[i];
            if (rs[i]) qa.push_back(rd[i]); else qb.push_back(rd[i]);
            @(negedge clk);
            chk("rt_ready", in_ready, 1);
            if (i > 0) begin
                chk("rt_valid", rs[i-1] ? a_valid : b_valid, 1);
                chk("rt_count", rs[i-1] ? a_count : b_count, 1);
            end
            step();
        end
        in_valid = 0;
        @(negedge clk);
        chk("rt_last_valid", a_valid, 1);
        chk("rt_last_count", a_count, 1);
        step();
        step();
        // full / backpressure on A while B still accepts
        a_ready = 0; b_ready = 0;
        send(1, 16'h00A0);
        send(1, 16'h00A1);
        in_data = 16'h00A2;
        @(negedge clk);
        chk("full_a_count", a_count, 2);
        chk("full_in_ready", in_ready, 0);
        step();
        in_sel = 0; in_data = 16'h00B0;
        @(negedge clk);
        chk("other_in_ready", in_ready, 1);
        qb.push_back(16'h00B0);
        step();
        in_valid = 0;
        @(negedge clk);
        chk("other_b_count", b_count, 1);
        chk("other_a_count", a_count, 2);
        step();
        // full with a same-cycle pop: push must still be refused
        in_valid = 1; in_sel = 1; in_data = 16'h00A2; a_ready = 1;
        @(negedge clk);
        chk("fp_in_ready", in_ready, 0);
        chk("fp_head_before", a_data, 16'h00A0);
        step();
        a_ready = 0;
        @(negedge clk);
        chk("fp_count_after_pop", a_count, 1);
        chk("fp_head_after", a_data, 16'h00A1);
        chk("fp_ready_again", in_ready, 1);
        qa.push_back(16'h00A2);
        step();
        in_valid = 0;
        @(negedge clk);
        chk("fp_refill_count", a_count, 2);
        step();
        a_ready = 1; b_ready = 1;
        repeat (4) step();
        @(negedge clk);
        chk("drain_a_count", a_count, 0);
        chk("drain_b_count", b_count, 0);
        step();
        // wrap-around on B with a toggling consumer
        tog = 1;
        for (int i = 0; i < 10; i++) send(0, 16'(i));
        in_valid = 0;
        tog = 0;
        step();
        b_ready = 1;
        repeat (4) step();
        @(negedge clk);
        chk("wrap_b_left", 32'(qb.size()), 0);
        chk("wrap_b_count", b_count, 0);
        step();
        // reset in the middle of traffic discards everything, including the push in flight
        a_ready = 0; b_ready = 0;
        send(1, 16'h0011);
        send(1, 16'h0022);
        send(0, 16'h0033);
        in_valid = 1; in_sel = 0; in_data = 16'h0044; reset = 1;
        qa.delete();
        qb.delete();
        step();
        reset = 0; in_valid = 0;
        @(negedge clk);
        chk("mid_a_count", a_count, 0);
        chk("mid_b_count", b_count, 0);
        chk("mid_a_valid", a_valid, 0);
        chk("mid_b_valid", b_valid, 0);
        step();
        send(1, 16'h0055);
        send(0, 16'h0066);
        in_valid = 0;
        @(negedge clk);
        chk("post_a_data", a_data, 16'h0055);
        chk("post_b_data", b_data, 16'h0066);
        chk("post_a_count", a_count, 1);
        chk("post_b_count", b_count, 1);
        step();
        a_ready = 1; b_ready = 1;
        repeat (3) step();
        @(negedge clk);
        chk("end_qa_empty", 32'(qa.size()), 0);
        chk("end_qb_empty", 32'(qb.size()), 0);
        chk("end_a_valid", a_valid, 0);
        chk("end_b_valid", b_valid, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmux16_2way_stream.md
Name: dmux16_2way_stream

Overview:
- Registered 1-to-2 demultiplexer for 16-bit data words: the inverse of the 16-bit 2-way mux.
- One input stream uses a valid/ready handshake. A per-word `sel` bit routes each accepted word to output port A or port B.
- Each output has its own small FIFO, so a stalled consumer on one side does not block words bound for the other side, except when the head input word targets the stalled side.
- Sits between a single producer (CPU or memory-mapped I/O path) and two independent consumers.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 2, entries per output FIFO; must be a power of 2 and at least 2.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived; not to be overridden).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word offered by the producer.
- in_sel  input  1  routing bit: 1 sends the word to port A, 0 sends it to port B (same polarity as the 2-way mux sel).
- in_valid  input  1  producer has a word on in_data/in_sel.
- in_ready  output  1  the FIFO addressed by in_sel can accept a word this cycle.
- a_data  output  WIDTH  head word of FIFO A.
- a_valid  output  1  FIFO A is non-empty.
- a_ready  input  1  consumer A takes the head word.
- a_count  output  CW  FIFO A occupancy.
- b_data  output  WIDTH  head word of FIFO B.
- b_valid  output  1  FIFO B is non-empty.
- b_ready  input  1  consumer B takes the head word.
- b_count  output  CW  FIFO B occupancy.

Behaviour:
- Reset (sampled on clk while reset=1):
  - Both FIFOs empty; pointers = 0; counts = 0.
  - a_valid = b_valid = 0; a_data = b_data = 0.
  - Reset takes precedence over any same-cycle push or pop. Words in flight mid-operation are discarded, not drained.
- in_ready:
  - Combinational: in_ready = in_sel ? (a_count != DEPTH) : (b_count != DEPTH).
  - Depends only on in_sel and registered occupancy, never on a_ready or b_ready (no combinational ready path through the block).
  - While reset=1, in_ready = 0.
- Push: in_valid && in_ready at a rising edge writes in_data into the selected FIFO at its write pointer. The write pointer increments modulo DEPTH.
- Pop A:
  - a_valid && a_ready removes the head word; the read pointer increments modulo DEPTH.
  - a_ready while a_valid=0 has no effect.
  - Pop B has the same rules.
- Counts:
  - a_count' = a_count + pushA − popA; b_count likewise.
  - Push and pop on the same FIFO in the same cycle leaves the count unchanged.
  - A FIFO that is full at the start of a cycle refuses the push, even if it also pops that cycle. Refusal is via in_ready=0; there is no pass-through on full.
- Latency:
  - A word accepted at edge N appears at the out port with *_valid=1 after edge N if that FIFO was empty.
  - Otherwise it appears behind older entries. There is no combinational in-to-out path.
- Ordering: FIFO order is preserved per port. No ordering guarantee exists between ports A and B.
- Head-of-line: if the producer holds in_valid with in_sel pointing at a full FIFO, the block does not reorder around it. The producer must wait.
- Data on an empty port: a_data/b_data show the storage slot at the read pointer; the value is don't-care while *_valid=0.
- Independence: a pop on A and a pop on B can occur in the same cycle together with one push to either side.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. full is defined as count == DEPTH, empty as count == 0.
- No over/underflow is possible by construction. Assertion in the bench: count never exceeds DEPTH.

Decomposition:
- Shared package (hack_pkg): WIDTH default word width (16) and a SEL_A = 1 / SEL_B = 0 routing constant, shared with the mux blocks.
- Sub-module fifo16_sync:
  - Parameterised WIDTH/DEPTH synchronous FIFO with push/pop, full/empty, count, head data.
  - Instantiated twice (A, B).
- Top level contains only:
  - the push decode (push_a = in_valid & in_ready & in_sel; push_b likewise with ~in_sel);
  - the in_ready mux.

Test Plan:
- Reset: drive in_valid=1, in_sel=1, in_data=16'hFFFF with reset=1 for 2 cycles → in_ready=0, a_valid=b_valid=0, counts=0, a_data=b_data=0. Release reset → first push at next edge, then a_valid=1 with a_data=16'hFFFF.
- Routing: a_ready=b_ready=1; push 16'h0001 (sel=1), 16'h0002 (sel=0), 16'h0003 (sel=1) on consecutive edges → A emits 0001, 0003 and B emits 0002, each 1 cycle after acceptance; counts never exceed 1.
- Full/backpressure: a_ready=0; push 16'h00A0 and 16'h00A1 to A → a_count=2 and in_ready=0 for sel=1. Present sel=0 with 16'h00B0 → accepted (in_ready=1); b_count=1.
- Full with simultaneous pop: A full, in_sel=1, in_valid=1, a_ready=1 for one cycle → push refused; a_count goes 2→1; a_data changes 00A0→00A1. Push is accepted the next cycle → a_count=2.
- Wrap-around: with DEPTH=2, stream 16'h0000..16'h0009 to B with b_ready toggling 1,0,1,0 → B emits all ten in order with no loss or duplication; b_count stays within 0..2.
- Reset mid-operation: A holds 2 words and B holds 1; assert reset for one cycle during a push → all counts=0, valids=0 next cycle. Stale words never reappear after new pushes.
